// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and frame-length helper shared by the UART blocks.
// Optional feature macro: AXIS_UART_TX_PARITY_EN (adds one even-parity bit per frame).
package uart_pkg;

   // Transmitter FSM states; the PARITY state only exists when parity is built in
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef AXIS_UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } uart_state_t;

`ifdef AXIS_UART_TX_PARITY_EN
   localparam int PARITY_BITS = 1;
`else
   localparam int PARITY_BITS = 0;
`endif

   // Bit-times in one frame: start + data + optional parity + stop bits
   function automatic int frame_bits(input int data_width, input int stop_bits);
      return 1 + data_width + PARITY_BITS + stop_bits;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-time counter producing a one-cycle tick on the last
// clock of every bit-time. Restart realigns the bit grid to a new frame.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic restart,
   input  logic enable,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   // Count 0..CLKS_PER_BIT-1 while enabled; held at zero when idle or restarting
   always_ff @(posedge clock) begin
      if (reset || restart || !enable) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = enable && !restart && (count == LAST);

endmodule

// File: rtl/axis_uart_tx.sv
// axis_uart_tx: drains a ready/valid byte stream onto an async serial line
// (start bit, LSB-first data, optional even parity, 1 or 2 stop bits).
// Optional feature macro: AXIS_UART_TX_PARITY_EN.
//
// Handshake: a word transfers on a rising edge where ivalid && iready.
// iready is high only in IDLE with reset low and never looks at ivalid;
// ivalid without iready has no effect and upstream must hold its word.
module axis_uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] idata,
   input  logic                  ivalid,
   output logic                  iready,
   output logic                  txd,
   output logic                  busy,
   output uart_state_t           dbg_state
);

   localparam int IW = $clog2(DATA_WIDTH + 1);
   localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_WIDTH - 1);
   localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

   uart_state_t           state;
   logic [DATA_WIDTH-1:0] shreg;
   logic [IW-1:0]         bit_idx;
   logic                  stop_idx;
   logic                  txd_q;
   logic                  accept;
   logic                  tick;
`ifdef AXIS_UART_TX_PARITY_EN
   logic                  par_q;
`endif

   assign iready    = (state == ST_IDLE) && !reset;
   assign accept    = ivalid && iready;
   assign busy      = (state != ST_IDLE);
   assign txd       = txd_q;
   assign dbg_state = state;

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clock  (clock),
      .reset  (reset),
      .restart(accept),
      .enable (busy),
      .tick   (tick)
   );

   // Frame sequencer: each tick closes the current bit-time and registers the next line level
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         txd_q    <= 1'b1;
         shreg    <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
`ifdef AXIS_UART_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  shreg    <= idata;
                  bit_idx  <= '0;
                  stop_idx <= 1'b0;
                  txd_q    <= 1'b0;
`ifdef AXIS_UART_TX_PARITY_EN
                  par_q    <= ^idata;
`endif
                  state    <= ST_START;
               end
            end
            ST_START: begin
               if (tick) begin
                  txd_q   <= shreg[0];
                  shreg   <= shreg >> 1;
                  bit_idx <= '0;
                  state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (bit_idx == LAST_BIT) begin
`ifdef AXIS_UART_TX_PARITY_EN
                     txd_q <= par_q;
                     state <= ST_PARITY;
`else
                     txd_q    <= 1'b1;
                     stop_idx <= 1'b0;
                     state    <= ST_STOP;
`endif
                  end else begin
                     txd_q   <= shreg[0];
                     shreg   <= shreg >> 1;
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
`ifdef AXIS_UART_TX_PARITY_EN
            ST_PARITY: begin
               if (tick) begin
                  txd_q    <= 1'b1;
                  stop_idx <= 1'b0;
                  state    <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (tick) begin
                  if (stop_idx == LAST_STOP) begin
                     state <= ST_IDLE;
                  end else begin
                     stop_idx <= stop_idx + 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               txd_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_uart_tx.sv
// tb_axis_uart_tx: two transmitter instances (A: 4 clk/bit, 1 stop; B: 2 clk/bit,
// 2 stops) checked every cycle against a frame-schedule model, plus literal checks.
module tb_axis_uart_tx;
   import uart_pkg::*;

   localparam int DW    = 8;
   localparam int CPB_A = 4;
   localparam int SB_A  = 1;
   localparam int CPB_B = 2;
   localparam int SB_B  = 2;
`ifdef AXIS_UART_TX_PARITY_EN
   localparam int          PAR      = 1;
   localparam logic [12:0] T1_LIT   = 13'h4AA;
   localparam int          T1_READY = 44;
   localparam int          T5_LOW   = 20;
`else
   localparam int          PAR      = 0;
   localparam logic [12:0] T1_LIT   = 13'h2AA;
   localparam int          T1_READY = 40;
   localparam int          T5_LOW   = 18;
`endif
   localparam int FB_A = 1 + DW + PAR + SB_A;
   localparam int FB_B = 1 + DW + PAR + SB_B;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   logic [DW-1:0] idata_a, idata_b;
   logic          ivalid_a, ivalid_b;
   logic          iready_a, iready_b, txd_a, txd_b, busy_a, busy_b;
   uart_state_t   dbg_a, dbg_b;

   axis_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB_A), .STOP_BITS(SB_A)) dut_a (
      .clock(clock), .reset(reset), .idata(idata_a), .ivalid(ivalid_a),
      .iready(iready_a), .txd(txd_a), .busy(busy_a), .dbg_state(dbg_a));

   axis_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB_B), .STOP_BITS(SB_B)) dut_b (
      .clock(clock), .reset(reset), .idata(idata_b), .ivalid(ivalid_b),
      .iready(iready_b), .txd(txd_b), .busy(busy_b), .dbg_state(dbg_b));

   // ---------------- scoreboard / counters ----------------
   int n_cmp = 0;
   int n_bad = 0;
   logic [DW-1:0] exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each instance holds at most one frame: the cycles [m_start, m_end) carry
   // frame bit (cycle - m_start) / clks_per_bit; outside that window the line is idle.
   int          m_start [2];
   int          m_end   [2];
   logic [15:0] m_bits  [2];
   logic [DW-1:0] rx_word;
   bit          rx_pend = 0;

   function automatic logic [15:0] frame_of(input logic [DW-1:0] d);
      logic [15:0] f;
      f    = '1;
      f[0] = 1'b0;
      for (int k = 0; k < DW; k++) f[1+k] = d[k];
      if (PAR == 1) f[1+DW] = ^d;
      return f;
   endfunction

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_start[i] = 0;
         m_end[i]   = 0;
         m_bits[i]  = '1;
      end
   end

   // compare process: every cycle after the first reset edge, both instances
   always @(negedge clock) begin
      if (cyc >= 1) begin
         for (int i = 0; i < 2; i++) begin
            int            cpb, fb, off;
            bit            inf;
            logic          e_txd, e_rdy, a_txd, a_busy, a_rdy, a_iv, a_st;
            logic [DW-1:0] a_d;
            cpb    = (i == 0) ? CPB_A : CPB_B;
            fb     = (i == 0) ? FB_A : FB_B;
            a_txd  = (i == 0) ? txd_a : txd_b;
            a_busy = (i == 0) ? busy_a : busy_b;
            a_rdy  = (i == 0) ? iready_a : iready_b;
            a_iv   = (i == 0) ? ivalid_a : ivalid_b;
            a_d    = (i == 0) ? idata_a : idata_b;
            a_st   = (i == 0) ? (dbg_a != ST_IDLE) : (dbg_b != ST_IDLE);
            inf    = (cyc >= m_start[i]) && (cyc < m_end[i]);
            off    = cyc - m_start[i];
            e_txd  = inf ? m_bits[i][off / cpb] : 1'b1;
            e_rdy  = !reset && !inf;
            chk($sformatf("inst%0d txd", i), 32'(a_txd), 32'(e_txd));
            chk($sformatf("inst%0d busy", i), 32'(a_busy), 32'(inf));
            chk($sformatf("inst%0d iready", i), 32'(a_rdy), 32'(e_rdy));
            chk($sformatf("inst%0d state_active", i), 32'(a_st), 32'(inf));
            // mid-bit receiver on instance A feeding the word scoreboard
            if (i == 0 && inf && rx_pend) begin
               if (off >= cpb && off < cpb * (1 + DW) && (off % cpb) == cpb / 2)
                  rx_word[off / cpb - 1] = a_txd;
               if (off == cpb * (1 + DW)) begin
                  chk("A word", 32'(rx_word), 32'(exp_q.pop_front()));
                  rx_pend = 0;
               end
            end
            // model update for the coming edge
            if (reset) begin
               if (m_end[i] > cyc + 1) m_end[i] = cyc + 1;
               if (i == 0 && rx_pend) begin
                  void'(exp_q.pop_front());
                  rx_pend = 0;
               end
            end else if (e_rdy && a_iv) begin
               m_start[i] = cyc + 1;
               m_end[i]   = cyc + 1 + fb * cpb;
               m_bits[i]  = frame_of(a_d);
               if (i == 0) begin
                  exp_q.push_back(a_d);
                  rx_pend = 1;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic to_drive();
      @(posedge clock);
      #1;
   endtask

   task automatic at_neg(input int n);
      do @(negedge clock); while (cyc < n);
   endtask

   // Present a word (call at posedge+1); returns the cycle whose closing edge accepted it.
   task automatic send(input int i, input logic [DW-1:0] d, input bit hold, output int acc_c);
      int n;
      n     = 0;
      acc_c = -1;
      if (i == 0) begin idata_a = d; ivalid_a = 1'b1; end
      else        begin idata_b = d; ivalid_b = 1'b1; end
      forever begin
         @(negedge clock);
         if (((i == 0) ? iready_a : iready_b) === 1'b1) begin
            acc_c = cyc;
            break;
         end
         n++;
         if (n > 400) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send timeout inst%0d: got no iready, expected one within 400 cycles", i);
            break;
         end
      end
      @(posedge clock);
      #1;
      if (!hold) begin
         if (i == 0) begin ivalid_a = 1'b0; idata_a = DW'($urandom); end
         else        begin ivalid_b = 1'b0; idata_b = DW'($urandom); end
      end
   endtask

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int c, c1, c2, s, n, h;
      logic [12:0] got;
      ivalid_a = 1'b0; ivalid_b = 1'b0;
      idata_a  = '0;   idata_b  = '0;
      reset    = 1'b1;
      @(negedge clock);
      chk("reset iready", 32'(iready_a), 32'd0);
      repeat (3) to_drive();
      reset = 1'b0;

      // idle after reset: line stays high, ready, not busy
      at_neg(cyc + 1000);
      chk("idle txd", 32'(txd_a), 32'd1);
      chk("idle busy", 32'(busy_a), 32'd0);
      chk("idle iready", 32'(iready_a), 32'd1);

      // 0x55 bit pattern and return to IDLE
      to_drive();
      send(0, 8'h55, 1'b0, c);
      s   = c + 1;
      got = '0;
      for (int k = 0; k < FB_A; k++) begin
         at_neg(s + k * CPB_A + 2);
         got[k] = txd_a;
      end
      chk("t1 frame bits", 32'(got), 32'(T1_LIT));
      at_neg(s + T1_READY - 1);
      chk("t1 iready before end", 32'(iready_a), 32'd0);
      at_neg(s + T1_READY);
      chk("t1 iready at end", 32'(iready_a), 32'd1);

      // back-to-back 0xA5 then 0x3C with ivalid held
      to_drive();
      send(0, 8'hA5, 1'b1, c1);
      idata_a = 8'h3C;
      at_neg(c1 + T1_READY);
      chk("t2 busy last stop", 32'(busy_a), 32'd1);
      chk("t2 txd last stop", 32'(txd_a), 32'd1);
      to_drive();
      send(0, 8'h3C, 1'b0, c2);
      chk("t2 accept spacing", 32'(c2 - c1), 32'(T1_READY + 1));
      at_neg(c2 + 1);
      chk("t2 second start", 32'(txd_a), 32'd0);
      at_neg(c2 + 1 + T1_READY);

      // reset in the middle of data bit 3 of 0xFF
      to_drive();
      send(0, 8'hFF, 1'b0, c);
      s = c + 1;
      at_neg(s + 4 * CPB_A);
      to_drive();
      reset = 1'b1;
      at_neg(s + 4 * CPB_A + 1);
      chk("t3 iready in reset", 32'(iready_a), 32'd0);
      chk("t3 txd data bit", 32'(txd_a), 32'd1);
      to_drive();
      reset = 1'b0;
      at_neg(s + 4 * CPB_A + 2);
      chk("t3 txd after reset", 32'(txd_a), 32'd1);
      chk("t3 busy after reset", 32'(busy_a), 32'd0);
      chk("t3 iready after reset", 32'(iready_a), 32'd1);
      to_drive();
      send(0, 8'h5A, 1'b0, c);
      at_neg(c + 1 + T1_READY);

`ifdef AXIS_UART_TX_PARITY_EN
      // parity bit values
      to_drive();
      send(0, 8'h07, 1'b0, c);
      at_neg(c + 1 + 9 * CPB_A + 2);
      chk("t4 parity of 07", 32'(txd_a), 32'd1);
      at_neg(c + 1 + T1_READY);
      to_drive();
      send(0, 8'h03, 1'b0, c);
      at_neg(c + 1 + 9 * CPB_A + 2);
      chk("t4 parity of 03", 32'(txd_a), 32'd0);
      at_neg(c + 1 + T1_READY);
`endif

      // instance B: 0x00 with two stop bits at 2 clocks per bit
      to_drive();
      send(1, 8'h00, 1'b0, c);
      s = c + 1;
      at_neg(s);
      n = 0;
      while (txd_b === 1'b0 && n < 40) begin n++; @(negedge clock); end
      chk("t5 low cycles", 32'(n), 32'(T5_LOW));
      h = 0;
      while (txd_b === 1'b1 && iready_b === 1'b0 && h < 40) begin h++; @(negedge clock); end
      chk("t5 stop cycles", 32'(h), 32'd4);
      chk("t5 iready after stops", 32'(iready_b), 32'd1);

      // randomized traffic on both instances
      to_drive();
      fork
         begin
            int cc;
            repeat (30) begin
               repeat ($urandom_range(0, 3)) to_drive();
               send(0, DW'($urandom), 1'($urandom_range(0, 1)), cc);
            end
            ivalid_a = 1'b0;
         end
         begin
            int cc;
            repeat (40) begin
               repeat ($urandom_range(0, 3)) to_drive();
               send(1, DW'($urandom), 1'($urandom_range(0, 1)), cc);
            end
            ivalid_b = 1'b0;
         end
      join
      at_neg(cyc + 80);
      chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axis_uart_tx.md
Name: axis_uart_tx

Overview:
Serial transmitter that drains the byte-stream FIFO's output port and shifts each word onto an asynchronous serial line (start bit, LSB-first data, optional parity, stop bits). It sits directly downstream of the FIFO. Its single-cycle ready/valid handshake applies backpressure while a frame is in flight. It drives the board TX pin through the top level.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
CLKS_PER_BIT, 16, clock cycles per serial bit; must be >= 2.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
clock  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
idata  input  DATA_WIDTH  word to transmit; sampled on handshake.
ivalid  input  1  upstream word valid.
iready  output  1  high only in IDLE and reset deasserted.
txd  output  1  serial line, registered, idle high.
busy  output  1  high from the cycle after accept until frame end.

Behaviour:
- One clock; reset is synchronous and active-high. Reset port is `reset`; clock port is `clock`.
- Reset (edge with reset=1):
  - state = IDLE, txd = 1, busy = 0, counters cleared.
  - iready is forced 0 while reset is high.
- Handshake: a transfer occurs on an edge with ivalid && iready. idata is latched into the shift register, and state moves to START.
  - ivalid without iready has no effect; upstream holds data (AXI-stream rule).
  - iready never depends combinationally on ivalid.
- States:
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY (macro on) or STOP after DATA_WIDTH bit-times.
  - PARITY -> STOP after one bit-time.
  - STOP -> IDLE after STOP_BITS bit-times.
- Timing: accept on edge T.
  - txd = 0 during cycles T+1 .. T+CLKS_PER_BIT.
  - Data bit k is driven during the following bit-times, LSB first, shifted from the latched copy.
  - IDLE (iready = 1) is re-entered exactly FRAME_BITS*CLKS_PER_BIT cycles after T+1.
  - FRAME_BITS = 1 + DATA_WIDTH + parity + STOP_BITS.
- Back-to-back: the next accept can occur in the first IDLE cycle. There is no extra idle gap beyond the stop bits plus that single accept cycle.
- Counters:
  - Bit-time counter width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps.
  - Bit index width $clog2(DATA_WIDTH+1).
  - No counter may overflow for the legal parameter range.
- txd is driven from a flop (glitch-free). busy = (state != IDLE).
- Reset mid-frame: the next edge returns txd to 1 and state to IDLE. The partially sent word is dropped, with no retransmit.
- idata changes after accept are ignored.

Optional Feature:
Macro AXIS_UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the latched data bits) is sent for one bit-time between the MSB and the first stop bit. FRAME_BITS includes it.
- Undefined: no PARITY state; the MSB is followed directly by the stop bits. No parity logic is synthesized.

Decomposition:
- Shared package (uart_pkg):
  - state encoding IDLE/START/DATA/PARITY/STOP as a localparam/typedef enum.
  - helper constant function computing FRAME_BITS.
- One natural sub-module, uart_baud_tick: bit-time counter emitting a one-cycle tick every CLKS_PER_BIT cycles, restarted on accept. Reused later by the receiver.

Test Plan:
1. CLKS_PER_BIT=4, accept 0x55 at T -> txd per 4-cycle bit: 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop); iready=1 again at T+41.
2. Two words 0xA5, 0x3C with ivalid held continuously -> second accepted in the first IDLE cycle after frame 1. No extra high gap on txd beyond the stop bit; busy low for exactly one cycle between frames.
3. Reset asserted one cycle in the middle of data bit 3 of 0xFF -> txd=1 on the next edge, busy=0, iready=0 during reset, 1 the cycle after. The next frame is transmitted intact.
4. AXIS_UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; frame length 11 bit-times.
5. STOP_BITS=2, CLKS_PER_BIT=2, send 0x00 -> txd low for 18 cycles, then high for 4 cycles, then iready=1.
6. ivalid held 0 for 1000 cycles after reset -> txd constantly 1, busy 0, iready 1.
